// File: rtl/alu_cmd_issue_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_cmd_issue_if : command, ALU-drive and result handshake bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface alu_cmd_issue_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3:0]               in_a;
  logic [3:0]               in_b;
  logic [2:0]               in_sel;
  logic [3:0]               alu_a;
  logic [3:0]               alu_b;
  logic [2:0]               alu_select;
  logic [4:0]               alu_out;
  logic                     res_valid;
  logic                     res_ready;
  logic [4:0]               res_data;
  logic [2:0]               res_sel;
  logic                     res_dz;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  in_valid, in_a, in_b, in_sel, alu_out, res_ready,
    output in_ready, alu_a, alu_b, alu_select, res_valid, res_data, res_sel, res_dz, count
  );

  modport master (
    output in_valid, in_a, in_b, in_sel, alu_out, res_ready,
    input  in_ready, alu_a, alu_b, alu_select, res_valid, res_data, res_sel, res_dz, count
  );
endinterface
`default_nettype wire

// File: rtl/alu_cmd_issue.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_cmd_issue : FIFO-buffered command issue to a combinational ALU with
//                 registered, zero-divisor-guarded result return
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_cmd_issue #(
  parameter int DEPTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  alu_cmd_issue_if.slave      bus
);
  localparam int             c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [10:0]         r_mem [DEPTH];
  logic [c_AW-1:0]     r_wr_ptr;
  logic [c_AW-1:0]     r_rd_ptr;
  logic [c_AW:0]       r_count;
  logic [3:0]          r_alu_a;
  logic [3:0]          r_alu_b;
  logic [2:0]          r_alu_sel;
  logic                r_res_valid;
  logic [4:0]          r_res_data;
  logic [2:0]          r_res_sel;
  logic                r_res_dz;
  logic                w_full;
  logic                w_nonempty;
  logic                w_push;
  logic                w_pop;
  logic                w_zdiv;
  logic [10:0]         w_head;

  assign w_full     = (r_count == c_FULL);
  assign w_nonempty = (r_count != '0);
  assign w_push     = bus.in_valid && !w_full;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_zdiv     = ((r_alu_sel == 3'b011) || (r_alu_sel == 3'b100)) && (r_alu_b == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.res_ready) begin
          w_pop       = w_nonempty;
          w_state_nxt = w_nonempty ? S_DRIVE : S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Storage array is not reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= {bus.in_a, bus.in_b, bus.in_sel};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_sel   <= '0;
      r_res_dz    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_alu_a   <= w_head[10:7];
        r_alu_b   <= w_head[6:3];
        r_alu_sel <= w_head[2:0];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      if (r_state == S_DRIVE) begin
        r_res_valid <= 1'b1;
        r_res_sel   <= r_alu_sel;
        r_res_data  <= w_zdiv ? 5'd0 : bus.alu_out;
        r_res_dz    <= w_zdiv;
      end else if ((r_state == S_HOLD) && bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = !w_full;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.alu_select = r_alu_sel;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_data   = r_res_data;
  assign bus.res_sel    = r_res_sel;
  assign bus.res_dz     = r_res_dz;
  assign bus.count      = r_count;
endmodule
`default_nettype wire
